tmds_video_sequencer: RTL
=========================

// Module: tmds_video_sequencer
// PURPOSE
//  Raster timing generator and period scheduler for the three TMDS encoder lanes.
//  Generates per-lane VDE/CD controls and the HDMI video preamble and guard-band window.
//  Generates pixel coordinates and pixel request for the framebuffer.
//  Sits between the pixel source and the blue/green/red encoders, in the pixel clock domain.
// PARAMETERS
//  H_ACTIVE   640  active pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   hsync width, pixels
//  H_BP       48   horizontal back porch, pixels; must be >=10 when DVI_MODE=0
//  V_ACTIVE   480  active lines
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  HSYNC_POL  0    asserted hsync level (0 = active-low)
//  VSYNC_POL  0    asserted vsync level
//  DVI_MODE   0    1 = no preamble/guard band; CTL0..3 held at 0
// PORTS
//  clk          in   1   pixel clock
//  rst          in   1   synchronous, active-high reset
//  vde          out  1   video data enable, common to all 3 encoders
//  cd0          out  2   lane0 (blue) CD = {vsync, hsync}
//  cd1          out  2   lane1 (green) CD = {CTL1, CTL0}
//  cd2          out  2   lane2 (red) CD = {CTL3, CTL2}
//  guard        out  1   1 = lanes must emit video guard band instead of encoder output
//  pix_req      out  1   pixel for (pix_x, pix_y) must be presented to encoders this cycle
//  pix_x        out  12  active-region x, valid when pix_req=1
//  pix_y        out  12  active-region y, valid when pix_req=1
//  frame_start  out  1   1-cycle pulse accompanying pixel (0,0)
// BEHAVIOUR
//  - Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*); v_cnt 0..V_TOTAL-1.
//    v_cnt increments when h_cnt wraps; v_cnt wraps to 0 after V_TOTAL-1.
//  - Region order per line: active [0,H_ACTIVE), FP, SYNC, BP. Region order per frame: active lines, FP, SYNC, BP.
//  - hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//    vsync asserted for whole lines with v_cnt in [V_ACTIVE+V_FP, +V_SYNC). Levels apply *_POL.
//  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. vde = pix_req = active.
//  - next_active: the line after the current one (wrapping V_TOTAL-1 -> 0) is < V_ACTIVE.
//  - Sequencer states, derived from counters and evaluated each cycle:
//    CONTROL: default; CTL0..3=0000; guard=0.
//    PREAMBLE: only when DVI_MODE=0 && next_active, for h_cnt in [H_TOTAL-10, H_TOTAL-3].
//      Lasts 8 cycles; CTL0..3=1,0,0,0 (cd1=2'b01, cd2=2'b00).
//    GUARD: same condition, h_cnt in [H_TOTAL-2, H_TOTAL-1]; 2 cycles; guard=1; vde=0; CTL=0000.
//    ACTIVE: active=1; vde=1; CTL=0000; guard=0.
//  - cd0 carries sync levels in every state; the encoder ignores it while vde=1.
//  - Latency: all outputs registered. The outputs at cycle t+1 describe the counter position at cycle t.
//    pix_x/pix_y/frame_start are aligned with vde.
//  - frame_start=1 only for position (0,0). pix_x=h_cnt, pix_y=v_cnt; zero when not active.
//  - Reset: h_cnt=v_cnt=0.
//    Outputs while rst=1 and the cycle after: vde=0, guard=0, pix_req=0, frame_start=0,
//    cd0={~VSYNC_POL,~HSYNC_POL}, cd1=cd2=0, pix_x=pix_y=0.
//  - First cycle after rst deasserts: counters at (0,0) with no preceding preamble/guard, which is accepted.
//    The next cycle shows pixel (0,0) with frame_start=1. Reset mid-frame has the same effect immediately.
//  - Wrap: the end of line V_TOTAL-1 carries preamble+guard, because line 0 is active.
//    The end of line V_ACTIVE-1 carries no preamble.
//  - guard and vde are never both 1. Preamble never overlaps hsync if H_BP>=10.
// TESTING
//  Params for all: H 8/2/3/12, V 4/1/2/2, POL=0 (H_TOTAL=25, V_TOTAL=9).
//  1 Reset held 5 cycles, release -> 1 idle cycle, then vde=1, frame_start=1, pix_x=0, pix_y=0;
//    vde stays high 8 cycles with pix_x 0..7.
//  2 Line 0 -> hsync (cd0[0]=0) for 3 cycles starting 10 cycles after frame_start; exactly 25 cycles per line.
//  3 End of line 0 -> cd1=01 for 8 cycles, then guard=1 for 2 cycles, then vde=1 with pix_y=1, no gap.
//  4 End of line 3 (last active) -> no preamble, no guard; lines 4..8 vde=0.
//    vsync (cd0[1]=0) on lines 5,6 for all 25 cycles each.
//  5 End of line 8 -> preamble+guard, then frame_start pulse; period between pulses = 225 cycles.
//  6 DVI_MODE=1 -> cd1=cd2=00 and guard=0 for 3 full frames.
//    rst pulsed mid-line 2 -> all outputs at reset values next cycle, then restart per test 1.

Source files
------------

// File: rtl/tmds_video_sequencer.sv
// Raster timing generator and TMDS period scheduler (control / preamble / guard / active).
// Outputs are registered and describe the counter position of the previous cycle.
module tmds_video_sequencer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit DVI_MODE  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        vde,
  output logic [1:0]  cd0,
  output logic [1:0]  cd1,
  output logic [1:0]  cd2,
  output logic        guard,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEGIN  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] PRE_BEGIN = 12'(H_TOTAL - 10);
  localparam logic [11:0] GRD_BEGIN = 12'(H_TOTAL - 2);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEGIN  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_CONTROL,
    ST_PREAMBLE,
    ST_GUARD,
    ST_ACTIVE
  } seq_state_t;

  logic [11:0] h_cnt, v_cnt, v_next;
  logic        active, next_active, hsync_on, vsync_on;
  seq_state_t  seq_state;

  logic        vde_d, guard_d, fs_d;
  logic [1:0]  cd0_d, cd1_d;
  logic [11:0] pix_x_d, pix_y_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= v_next;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Period is decoded from the counters each cycle; the output register supplies the one-cycle latency.
  always_comb begin
    seq_state   = ST_CONTROL;
    v_next      = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    next_active = (v_next < V_ACT);
    hsync_on    = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
    vsync_on    = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

    if (active)
      seq_state = ST_ACTIVE;
    else if (!DVI_MODE && next_active && (h_cnt >= GRD_BEGIN))
      seq_state = ST_GUARD;
    else if (!DVI_MODE && next_active && (h_cnt >= PRE_BEGIN))
      seq_state = ST_PREAMBLE;

    vde_d   = (seq_state == ST_ACTIVE);
    guard_d = (seq_state == ST_GUARD);
    cd1_d   = (seq_state == ST_PREAMBLE) ? 2'b01 : 2'b00;
    cd0_d   = {vsync_on ? VSYNC_POL : ~VSYNC_POL, hsync_on ? HSYNC_POL : ~HSYNC_POL};
    pix_x_d = active ? h_cnt : 12'd0;
    pix_y_d = active ? v_cnt : 12'd0;
    fs_d    = active && (h_cnt == 12'd0) && (v_cnt == 12'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vde         <= 1'b0;
      guard       <= 1'b0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      cd0         <= {~VSYNC_POL, ~HSYNC_POL};
      cd1         <= 2'b00;
      pix_x       <= '0;
      pix_y       <= '0;
    end else begin
      vde         <= vde_d;
      guard       <= guard_d;
      pix_req     <= vde_d;
      frame_start <= fs_d;
      cd0         <= cd0_d;
      cd1         <= cd1_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
    end
  end

  // CTL2/CTL3 are zero in every period, including preamble.
  assign cd2 = 2'b00;

endmodule
